// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle sequencer driving bus strobes and ALU opcode for one operation at a time
module alu_op_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter logic [4:0]  NOP_OPCODE    = 5'b11001
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_opcode,
  input  logic [3:0] req_ra,
  input  logic [3:0] req_rb,
  input  logic [3:0] req_rz,
  output logic [3:0] rf_sel,
  output logic       gpr_out,
  output logic       gpr_in,
  output logic       y_in,
  output logic       z_in,
  output logic       zlo_out,
  output logic       zhi_out,
  output logic       lo_in,
  output logic       hi_in,
  output logic [4:0] alu_opcode,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_Y = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB_LO  = 3'd3;
  localparam logic [2:0] S_WB_HI  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [7:0] CNT_LAST = 8'(MULDIV_CYCLES - 1);

  function automatic logic is_binary(input logic [4:0] op);
    return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110,
                      5'b00111, 5'b01000, 5'b01001, 5'b01010};
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return op inside {5'b10000, 5'b10001};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {5'b01110, 5'b01111};
  endfunction

  logic [2:0] state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [3:0] ra_q, ra_d, rb_q, rb_d, rz_q, rz_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_flag_q, err_flag_d;

  logic [3:0] rf_sel_q, rf_sel_d;
  logic       gpr_out_q, gpr_out_d, gpr_in_q, gpr_in_d;
  logic       y_in_q, y_in_d, z_in_q, z_in_d;
  logic       zlo_out_q, zlo_out_d, zhi_out_q, zhi_out_d;
  logic       lo_in_q, lo_in_d, hi_in_q, hi_in_d;
  logic [4:0] alu_opcode_q, alu_opcode_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d, req_ready_q, req_ready_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    rz_d       = rz_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d       = req_opcode;
          ra_d       = req_ra;
          rb_d       = req_rb;
          rz_d       = req_rz;
          cnt_d      = 8'd0;
          err_flag_d = !(is_binary(req_opcode) || is_unary(req_opcode) || is_muldiv(req_opcode));
          if (err_flag_d)                state_d = S_DONE;
          else if (is_unary(req_opcode)) state_d = S_EXEC;
          else                           state_d = S_LOAD_Y;
        end
      end
      S_LOAD_Y: begin
        cnt_d   = 8'd0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // The compare against CNT_LAST stops the count well before 8'hff, so it never wraps.
        if (is_muldiv(op_q) && cnt_q != CNT_LAST) cnt_d = cnt_q + 8'd1;
        else                                      state_d = S_WB_LO;
      end
      S_WB_LO: state_d = is_muldiv(op_q) ? S_WB_HI : S_DONE;
      S_WB_HI: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe comes straight off a flop.
  always_comb begin
    rf_sel_d     = 4'd0;
    gpr_out_d    = 1'b0;
    gpr_in_d     = 1'b0;
    y_in_d       = 1'b0;
    z_in_d       = 1'b0;
    zlo_out_d    = 1'b0;
    zhi_out_d    = 1'b0;
    lo_in_d      = 1'b0;
    hi_in_d      = 1'b0;
    alu_opcode_d = NOP_OPCODE;
    busy_d       = (state_d != S_IDLE);
    done_d       = 1'b0;
    err_d        = 1'b0;
    req_ready_d  = (state_d == S_IDLE);
    case (state_d)
      S_LOAD_Y: begin
        rf_sel_d  = ra_d;
        gpr_out_d = 1'b1;
        y_in_d    = 1'b1;
      end
      S_EXEC: begin
        rf_sel_d     = rb_d;
        gpr_out_d    = 1'b1;
        alu_opcode_d = op_d;
        z_in_d       = !is_muldiv(op_d) || (cnt_d == CNT_LAST);
      end
      S_WB_LO: begin
        zlo_out_d = 1'b1;
        if (is_muldiv(op_d)) begin
          lo_in_d = 1'b1;
        end else begin
          rf_sel_d = rz_d;
          gpr_in_d = 1'b1;
        end
      end
      S_WB_HI: begin
        zhi_out_d = 1'b1;
        hi_in_d   = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = err_flag_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= S_IDLE;
      op_q         <= 5'd0;
      ra_q         <= 4'd0;
      rb_q         <= 4'd0;
      rz_q         <= 4'd0;
      cnt_q        <= 8'd0;
      err_flag_q   <= 1'b0;
      rf_sel_q     <= 4'd0;
      gpr_out_q    <= 1'b0;
      gpr_in_q     <= 1'b0;
      y_in_q       <= 1'b0;
      z_in_q       <= 1'b0;
      zlo_out_q    <= 1'b0;
      zhi_out_q    <= 1'b0;
      lo_in_q      <= 1'b0;
      hi_in_q      <= 1'b0;
      alu_opcode_q <= NOP_OPCODE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      rz_q         <= rz_d;
      cnt_q        <= cnt_d;
      err_flag_q   <= err_flag_d;
      rf_sel_q     <= rf_sel_d;
      gpr_out_q    <= gpr_out_d;
      gpr_in_q     <= gpr_in_d;
      y_in_q       <= y_in_d;
      z_in_q       <= z_in_d;
      zlo_out_q    <= zlo_out_d;
      zhi_out_q    <= zhi_out_d;
      lo_in_q      <= lo_in_d;
      hi_in_q      <= hi_in_d;
      alu_opcode_q <= alu_opcode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) assert ($onehot0({gpr_out_q, zlo_out_q, zhi_out_q}));
  end

  assign req_ready  = req_ready_q;
  assign rf_sel     = rf_sel_q;
  assign gpr_out    = gpr_out_q;
  assign gpr_in     = gpr_in_q;
  assign y_in       = y_in_q;
  assign z_in       = z_in_q;
  assign zlo_out    = zlo_out_q;
  assign zhi_out    = zhi_out_q;
  assign lo_in      = lo_in_q;
  assign hi_in      = hi_in_q;
  assign alu_opcode = alu_opcode_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  localparam logic [4:0] NOP = 5'b11001;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_opcode = 5'd0;
  logic [3:0] req_ra = 4'd0, req_rb = 4'd0, req_rz = 4'd0;
  logic [3:0] rf_sel;
  logic       gpr_out, gpr_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;
  logic [4:0] alu_opcode;
  logic       busy, done, err;

  int tests = 0;
  int failed = 0;

  alu_op_sequencer #(.MULDIV_CYCLES(4), .NOP_OPCODE(NOP)) dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_ra(req_ra), .req_rb(req_rb), .req_rz(req_rz),
    .rf_sel(rf_sel), .gpr_out(gpr_out), .gpr_in(gpr_in), .y_in(y_in), .z_in(z_in),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in),
    .alu_opcode(alu_opcode), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {rf_sel, gpr_out, gpr_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in,
                alu_opcode, busy, done, err, req_ready};

  // strb = {gpr_out, gpr_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in}; fl = {busy, done, err, req_ready}
  function automatic logic [20:0] v(input logic [3:0] rf, input logic [7:0] strb,
                                    input logic [4:0] op, input logic [3:0] fl);
    return {rf, strb, op, fl};
  endfunction

  task automatic cmp(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [20:0] e);
    cmp(tag, 32'(obs), 32'(e));
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rz);
    req_valid = 1'b1; req_opcode = op; req_ra = ra; req_rb = rb; req_rz = rz;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (clear) begin
      tests++;
      assert ($onehot0({gpr_out, zlo_out, zhi_out})) else begin
        failed++;
        $error("FAIL bus_excl observed=%b expected=onehot0", {gpr_out, zlo_out, zhi_out});
      end
    end
  end

  int acc [3];
  int n;

  initial begin
    acc = '{0, 0, 0};
    n = 0;
    @(negedge clk); @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    step("idle_after_reset", v(4'd0, 8'b0, NOP, 4'b0001));

    issue(5'b00011, 4'd2, 4'd3, 4'd4);
    step("add_load_y", v(4'd2, 8'b1010_0000, NOP, 4'b1000));
    step("add_exec",   v(4'd3, 8'b1001_0000, 5'b00011, 4'b1000));
    step("add_wb_lo",  v(4'd4, 8'b0100_1000, NOP, 4'b1000));
    step("add_done",   v(4'd0, 8'b0, NOP, 4'b1100));
    step("add_idle",   v(4'd0, 8'b0, NOP, 4'b0001));

    issue(5'b10001, 4'd0, 4'd7, 4'd1);
    step("not_exec",   v(4'd7, 8'b1001_0000, 5'b10001, 4'b1000));
    step("not_wb_lo",  v(4'd1, 8'b0100_1000, NOP, 4'b1000));
    step("not_done",   v(4'd0, 8'b0, NOP, 4'b1100));
    step("not_idle",   v(4'd0, 8'b0, NOP, 4'b0001));

    issue(5'b01110, 4'd5, 4'd6, 4'd9);
    step("mul_load_y", v(4'd5, 8'b1010_0000, NOP, 4'b1000));
    step("mul_exec1",  v(4'd6, 8'b1000_0000, 5'b01110, 4'b1000));
    step("mul_exec2",  v(4'd6, 8'b1000_0000, 5'b01110, 4'b1000));
    step("mul_exec3",  v(4'd6, 8'b1000_0000, 5'b01110, 4'b1000));
    step("mul_exec4",  v(4'd6, 8'b1001_0000, 5'b01110, 4'b1000));
    step("mul_wb_lo",  v(4'd0, 8'b0000_1010, NOP, 4'b1000));
    step("mul_wb_hi",  v(4'd0, 8'b0000_0101, NOP, 4'b1000));
    step("mul_done",   v(4'd0, 8'b0, NOP, 4'b1100));
    step("mul_idle",   v(4'd0, 8'b0, NOP, 4'b0001));

    issue(5'b00000, 4'd1, 4'd2, 4'd3);
    step("ill_done",   v(4'd0, 8'b0, NOP, 4'b1110));
    step("ill_idle",   v(4'd0, 8'b0, NOP, 4'b0001));

    req_valid = 1'b1; req_opcode = 5'b00011; req_ra = 4'd1; req_rb = 4'd2; req_rz = 4'd3;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (req_valid && req_ready && n < 3) begin
        acc[n] = cyc;
        n++;
      end
      if (n == 1 && cyc == acc[0] + 1) req_rz = 4'd12;
      if (n == 1 && cyc == acc[0] + 3)
        cmp("b2b_wb_rz_held", 32'(obs), 32'(v(4'd3, 8'b0100_1000, NOP, 4'b1000)));
      if (n == 3 && cyc == acc[2] + 1) req_valid = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    cmp("b2b_accepts", n, 3);
    cmp("b2b_gap1", acc[1] - acc[0], 5);
    cmp("b2b_gap2", acc[2] - acc[1], 5);
    step("b2b_idle", v(4'd0, 8'b0, NOP, 4'b0001));

    issue(5'b01110, 4'd5, 4'd6, 4'd9);
    @(negedge clk);
    cmp("pre_reset_exec", 32'(obs), 32'(v(4'd6, 8'b1000_0000, 5'b01110, 4'b1000)));
    clear = 1'b0;
    @(negedge clk);
    cmp("reset_mid_mul", 32'(obs & ~21'd1), 32'(v(4'd0, 8'b0, NOP, 4'b0000)));
    clear = 1'b1;
    @(negedge clk);
    step("reset_release", v(4'd0, 8'b0, NOP, 4'b0001));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control FSM that sequences one register-to-register ALU operation at a time over the shared bus.
- Per operation it drives register-file select/strobes, Y/Z/HI/LO latch enables and the 5-bit ALU opcode through operand load, execute and writeback.
- Sits between instruction decode (requester) and the ALU datapath.
- Mul/div are held in EXEC for a programmable number of cycles and write back to HI/LO.

Parameters:
MULDIV_CYCLES, 4, cycles EXEC is held for mul/div (legal 1..255); z_in fires on the last one.
NOP_OPCODE, 5'b11001, opcode driven to the ALU whenever the FSM is not in EXEC.

Ports:
clk  in  1  system clock, rising edge.
clear  in  1  asynchronous, active-low reset.
req_valid  in  1  requester has an operation.
req_ready  out  1  sequencer can accept; transfer on req_valid & req_ready at a rising edge.
req_opcode  in  5  ALU opcode (team encoding).
req_ra  in  4  source A register.
req_rb  in  4  source B register.
req_rz  in  4  destination register (ignored for mul/div).
rf_sel  out  4  register-file select for the current bus access.
gpr_out  out  1  selected register drives bus.
gpr_in  out  1  selected register loads from bus.
y_in  out  1  Y register load.
z_in  out  1  64-bit Z register load.
zlo_out  out  1  Z[31:0] drives bus.
zhi_out  out  1  Z[63:32] drives bus.
lo_in  out  1  LO register load.
hi_in  out  1  HI register load.
alu_opcode  out  5  opcode presented to the ALU.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  valid with done; 1 = illegal opcode, no state changed.

Behaviour:
- Reset (clear=0, any time, including mid-operation):
  - state = IDLE; all strobes 0; alu_opcode = NOP_OPCODE; rf_sel = 0; counter = 0; busy/done/err = 0.
  - req_ready is 1 once clear deasserts.
- Opcode classes:
  - Binary: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - Unary (B only): neg 10000, not 10001.
  - Mul/div: mul 01110, div 01111.
  - Any other opcode is illegal.
- Operand capture: opcode, ra, rb and rz are registered at acceptance and held until DONE. Request inputs are ignored while busy.
- FSM, all outputs registered (Moore), one state per cycle unless noted:
  - IDLE: req_ready=1. On accept, go to DONE with err=1 if illegal; to EXEC if unary; otherwise to LOAD_Y.
  - LOAD_Y: rf_sel=ra, gpr_out=1, y_in=1. Next state EXEC.
  - EXEC: rf_sel=rb, gpr_out=1, alu_opcode=captured op.
    - Binary/unary: z_in=1; 1 cycle, then WB_LO.
    - Mul/div: counter counts MULDIV_CYCLES cycles; z_in=1 only on the final cycle; then WB_LO.
  - WB_LO: zlo_out=1.
    - Binary/unary: rf_sel=rz, gpr_in=1; next DONE.
    - Mul/div: lo_in=1; next WB_HI.
  - WB_HI (mul/div only): zhi_out=1, hi_in=1. Next DONE.
  - DONE: done=1, err valid, req_ready=0. Next IDLE.
- Latency (accept edge to done pulse):
  - Binary: 4 cycles.
  - Unary: 3 cycles.
  - Mul/div: MULDIV_CYCLES+4 cycles.
  - Illegal: 1 cycle.
- Back-to-back requests: the next request can be accepted the cycle after DONE (IDLE). Minimum issue interval = latency+1.
- Bus exclusivity: at most one of gpr_out, zlo_out, zhi_out is high in any cycle. Checked by assertion.
- rz=ra or rz=rb is legal: operands are latched in Y/Z before writeback.
- MULDIV_CYCLES=1: EXEC lasts exactly 1 cycle, with z_in in that cycle.
- Counter is 8 bits; it resets to 0 on entering EXEC and never wraps.

Test Plan:
- Reset: clear=0 mid-EXEC of a mul → next cycle busy=0, all strobes 0, alu_opcode=11001; after clear=1, req_ready=1.
- add ra=2 rb=3 rz=4 → LOAD_Y (rf_sel=2, y_in), EXEC (rf_sel=3, opcode 00011, z_in), WB_LO (rf_sel=4, gpr_in, zlo_out), done at cycle 4, err=0.
- not rb=7 rz=1 → no y_in cycle; EXEC opcode 10001; done at cycle 3.
- mul with MULDIV_CYCLES=4 → EXEC held 4 cycles, z_in only on the 4th; then lo_in+zlo_out, then hi_in+zhi_out; done at cycle 8; gpr_in never asserted.
- Illegal opcode 00000 → done=1, err=1 one cycle after accept; no strobes asserted.
- req_valid held high continuously over 3 adds → accepts spaced 5 cycles apart; req_valid while busy ignored; bus-exclusivity assertion holds throughout.
